// File: rtl/foo_arb_pkg.sv
// Shared types and defaults for the foo_if round-robin arbiter and its picker.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package foo_arb_pkg;

    localparam int FOO_NUM_REQ   = 4;
    localparam int FOO_DATA_W    = 32;
    localparam int FOO_MAX_BURST = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Index width for a vector of n entries, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [idx_w(FOO_NUM_REQ)-1:0] req_idx_t;

endpackage

// File: rtl/foo_rr_pick.sv
// Combinational round-robin picker: first valid index after last_winner, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller decides when the pick is used.
module foo_rr_pick
    import foo_arb_pkg::*;
#(
    parameter int NUM_REQ = FOO_NUM_REQ,
    parameter int IW      = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IW-1:0]      last_winner,
    output logic [IW-1:0]      winner,
    output logic               any
);

    logic [IW:0] cand;
    logic        found;

    // Walk last_winner+1 .. last_winner+NUM_REQ modulo NUM_REQ; first valid wins.
    // cand never reaches 2*NUM_REQ, so one conditional subtract is a full modulo.
    always_comb begin
        winner = last_winner;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_winner} + (IW+1)'(k);
            if (cand >= (IW+1)'(NUM_REQ)) begin
                cand = cand - (IW+1)'(NUM_REQ);
            end
            if (!found && valid[cand[IW-1:0]]) begin
                winner = cand[IW-1:0];
                found  = 1'b1;
            end
        end
    end

    assign any = |valid;

endmodule

// File: rtl/foo_arb.sv
// Round-robin burst arbiter merging NUM_REQ valid/ready sources onto one foo_if stream.
// Latency: 1 cycle IDLE arbitration, then accepted beat appears on out_* the next cycle.
// Backpressure: owner's req_ready = out_ready | ~out_valid; all other req_ready held low.
module foo_arb
    import foo_arb_pkg::*;
#(
    parameter int NUM_REQ   = FOO_NUM_REQ,
    parameter int DATA_W    = FOO_DATA_W,
    parameter int MAX_BURST = FOO_MAX_BURST
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_last,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       out_ready,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [IW-1:0]     last_winner;
    logic [CW-1:0]     beat_cnt;
    logic [IW-1:0]     pick_winner;
    logic              pick_any;
    logic              own_valid;
    logic              own_last;
    logic [DATA_W-1:0] own_data;
    logic              slot_free;
    logic              accept;
    logic              burst_end;

    foo_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .valid       (req_valid),
        .last_winner (last_winner),
        .winner      (pick_winner),
        .any         (pick_any)
    );

    // Select the current owner's valid/last/data lanes.
    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_id == IW'(i)) begin
                own_valid = req_valid[i];
                own_last  = req_last[i];
                own_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign slot_free = out_ready | ~out_valid;
    assign accept    = (state == BURST) & own_valid & slot_free;
    assign burst_end = accept & (own_last | (beat_cnt == CW'(MAX_BURST - 1)));
    assign busy      = (state == BURST);

    // Only the owner sees ready, and only while the output slot can take a beat.
    always_comb begin
        req_ready = '0;
        if (state == BURST) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt_id == IW'(i)) begin
                    req_ready[i] = slot_free;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: grant on any request in IDLE, return to IDLE when the burst closes.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_any)  state_nxt = BURST;
            BURST:   if (burst_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant bookkeeping: owner latch, beat count and round-robin pointer.
    // last_winner resets to the top index so requester 0 is scanned first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_id      <= '0;
            beat_cnt    <= '0;
            last_winner <= IW'(NUM_REQ - 1);
        end else begin
            if (state == IDLE && pick_any) begin
                gnt_id   <= pick_winner;
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + CW'(1);
            end
            if (burst_end) begin
                last_winner <= gnt_id;
            end
        end
    end

    // One-entry output register; data holds its last value once drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= own_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_foo_arb.sv
// Self-checking bench for foo_arb: per-cycle reference model plus directed stream checks.
// Latency: n/a.
// Backpressure: out_ready driven by the scenarios.
module tb_foo_arb;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NR-1:0]  req_valid;
    logic [NR-1:0]  req_last;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]  req_ready;
    logic           out_valid;
    logic [DW-1:0]  out_data;
    logic           out_ready;
    logic [1:0]     gnt_id;
    logic           busy;

    foo_arb #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .gnt_id    (gnt_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- stimulus storage: per-requester beat lists ----------------
    logic [DW-1:0] bd [NR][16];
    bit            bl [NR][16];
    int            bn [NR];
    int            bp [NR];
    bit            hold [NR];

    logic [DW-1:0] obs[$];
    int            obs_cyc[$];
    int            gnts[$];
    int            gnt_cyc[$];
    logic [DW-1:0] exp_q[$];
    int            exp_g[$];

    always_comb begin
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        for (int i = 0; i < NR; i++) begin
            req_valid[i]          = (bp[i] < bn[i]) && !hold[i];
            req_last[i]           = bl[i][bp[i] % 16];
            req_data[i*DW +: DW]  = bd[i][bp[i] % 16];
        end
    end

    task automatic clear_stim();
        for (int i = 0; i < NR; i++) begin
            bn[i]   = 0;
            bp[i]   = 0;
            hold[i] = 1'b0;
            for (int j = 0; j < 16; j++) begin
                bd[i][j] = '0;
                bl[i][j] = 1'b0;
            end
        end
        obs.delete();
        obs_cyc.delete();
        gnts.delete();
        gnt_cyc.delete();
    endtask

    task automatic push(input int r, input logic [DW-1:0] d, input bit l);
        bd[r][bn[r]] = d;
        bl[r][bn[r]] = l;
        bn[r]++;
    endtask

    function automatic bit all_taken();
        for (int i = 0; i < NR; i++) begin
            if (bp[i] != bn[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Source side: a beat is consumed when valid&ready was seen before the edge.
    initial begin
        logic [NR-1:0] f;
        forever begin
            @(negedge clk);
            f = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (f[i] && rst_n) bp[i]++;
            end
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    bit            m_burst;
    int            m_owner;
    int            m_lastw;
    int            m_taken;
    bit            m_vld;
    logic [DW-1:0] m_dat;
    logic [DW-1:0] m_nd;
    bit            m_acc;
    bit            m_found;
    int            m_c;
    logic [NR-1:0] m_rdy;
    bit            busy_prev;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                m_burst   = 1'b0;
                m_owner   = 0;
                m_lastw   = NR - 1;
                m_taken   = 0;
                m_vld     = 1'b0;
                m_dat     = '0;
                busy_prev = 1'b0;
            end
            m_rdy = '0;
            if (m_burst && (out_ready || !m_vld)) m_rdy[m_owner] = 1'b1;
            chk("mdl_out_valid", out_valid, m_vld);
            chk("mdl_out_data",  out_data,  m_dat);
            chk("mdl_gnt_id",    gnt_id,    m_owner);
            chk("mdl_busy",      busy,      m_burst);
            chk("mdl_req_ready", req_ready, m_rdy);

            if (out_valid && out_ready) begin
                obs.push_back(out_data);
                obs_cyc.push_back(cyc);
            end
            if (busy && !busy_prev) begin
                gnts.push_back(int'(gnt_id));
                gnt_cyc.push_back(cyc);
            end
            busy_prev = busy;

            if (rst_n) begin
                m_acc = 1'b0;
                m_nd  = '0;
                if (!m_burst) begin
                    if (req_valid != '0) begin
                        m_found = 1'b0;
                        for (int k = 1; k <= NR; k++) begin
                            m_c = (m_lastw + k) % NR;
                            if (!m_found && req_valid[m_c]) begin
                                m_owner = m_c;
                                m_found = 1'b1;
                            end
                        end
                        m_burst = 1'b1;
                        m_taken = 0;
                    end
                end else if (req_valid[m_owner] && (out_ready || !m_vld)) begin
                    m_acc = 1'b1;
                    m_nd  = req_data[m_owner*DW +: DW];
                    m_taken++;
                    if (req_last[m_owner] || m_taken == MB) begin
                        m_burst = 1'b0;
                        m_lastw = m_owner;
                    end
                end
                if (m_acc) begin
                    m_vld = 1'b1;
                    m_dat = m_nd;
                end else if (out_ready) begin
                    m_vld = 1'b0;
                end
            end
        end
    end

    // ---------------- scenario helpers ----------------
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        clear_stim();
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic drain(input string nm);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        while (!done && n < 300) begin
            @(posedge clk);
            #2;
            n++;
            done = all_taken() && !out_valid;
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_drain: not drained after %0d cycles, required drained", nm, n);
        end
    endtask

    task automatic wait_obs(input string nm, input int cnt);
        int n;
        n = 0;
        while (obs.size() < cnt && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk({nm, "_wait_obs"}, obs.size() >= cnt, 1);
    endtask

    task automatic wait_bp(input string nm, input int r, input int cnt);
        int n;
        n = 0;
        while (bp[r] < cnt && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk({nm, "_wait_accept"}, bp[r] >= cnt, 1);
    endtask

    task automatic check_stream(input string nm);
        chk({nm, "_count"}, obs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            chk($sformatf("%s_beat%0d", nm, i), obs[i], exp_q[i]);
        end
        exp_q.delete();
    endtask

    task automatic check_grants(input string nm);
        chk({nm, "_grants"}, gnts.size(), exp_g.size());
        for (int i = 0; i < exp_g.size() && i < gnts.size(); i++) begin
            chk($sformatf("%s_grant%0d", nm, i), gnts[i], exp_g[i]);
        end
        exp_g.delete();
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int t0;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        clear_stim();
        repeat (2) @(posedge clk);
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data",  out_data,  0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_gnt_id",    gnt_id,    0);
        chk("rst_busy",      busy,      0);
        rst_n = 1'b1;

        // Single requester, 3-beat burst.
        @(posedge clk);
        #2;
        t0 = cyc + 1;
        push(2, 32'hCAFEDECA, 1'b0);
        push(2, 32'hCAFEDECB, 1'b0);
        push(2, 32'hCAFEDECC, 1'b1);
        drain("t1");
        exp_q.push_back(32'hCAFEDECA);
        exp_q.push_back(32'hCAFEDECB);
        exp_q.push_back(32'hCAFEDECC);
        if (obs_cyc.size() == 3) begin
            chk("t1_first_latency", obs_cyc[0] - t0, 2);
            chk("t1_back_to_back",  obs_cyc[2] - obs_cyc[0], 2);
        end
        check_stream("t1");
        exp_g.push_back(2);
        check_grants("t1");
        chk("t1_gnt_id_end", gnt_id, 2);
        chk("t1_busy_end",   busy,   0);

        // Round-robin fairness with single-beat bursts.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < NR; r++) begin
                push(r, 32'h100 + 32'(r * 16 + k), 1'b1);
            end
        end
        drain("t2");
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < NR; r++) begin
                exp_q.push_back(32'h100 + 32'(r * 16 + k));
                exp_g.push_back(r);
            end
        end
        if (gnt_cyc.size() == 8) begin
            for (int i = 1; i < 8; i++) begin
                chk($sformatf("t2_gap%0d", i), gnt_cyc[i] - gnt_cyc[i-1], 2);
            end
        end
        check_stream("t2");
        check_grants("t2");

        // MAX_BURST cut with a competing requester.
        do_reset();
        for (int k = 0; k < 6; k++) push(1, 32'h1A0 + 32'(k), 1'b0);
        push(3, 32'h3B0, 1'b0);
        push(3, 32'h3B1, 1'b1);
        drain("t3");
        for (int k = 0; k < 4; k++) exp_q.push_back(32'h1A0 + 32'(k));
        exp_q.push_back(32'h3B0);
        exp_q.push_back(32'h3B1);
        exp_q.push_back(32'h1A4);
        exp_q.push_back(32'h1A5);
        check_stream("t3");
        exp_g.push_back(1);
        exp_g.push_back(3);
        exp_g.push_back(1);
        check_grants("t3");
        chk("t3_owner_held", busy, 1);

        // Output back-pressure for 5 cycles mid-burst.
        do_reset();
        for (int k = 0; k < 6; k++) push(0, 32'h0A0 + 32'(k), k == 5);
        wait_obs("t4", 2);
        out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("t4_stall_data",  out_data,  32'h0A2);
            chk("t4_stall_valid", out_valid, 1);
            chk("t4_stall_ready", req_ready, 0);
        end
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain("t4");
        for (int k = 0; k < 6; k++) exp_q.push_back(32'h0A0 + 32'(k));
        check_stream("t4");
        exp_g.push_back(0);
        exp_g.push_back(0);
        check_grants("t4");

        // Owner stalls its valid while requester 0 waits.
        do_reset();
        for (int k = 0; k < 4; k++) push(2, 32'h2C0 + 32'(k), k == 3);
        wait_bp("t5", 2, 2);
        hold[2] = 1'b1;
        push(0, 32'h0C0, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("t5_req0_ready", req_ready[0], 0);
            chk("t5_gnt_kept",   gnt_id,       2);
            chk("t5_busy",       busy,         1);
        end
        @(posedge clk);
        #2;
        hold[2] = 1'b0;
        drain("t5");
        for (int k = 0; k < 4; k++) exp_q.push_back(32'h2C0 + 32'(k));
        exp_q.push_back(32'h0C0);
        check_stream("t5");
        exp_g.push_back(2);
        exp_g.push_back(0);
        check_grants("t5");

        // Reset during beat 2 of a burst.
        do_reset();
        for (int k = 0; k < 3; k++) push(2, 32'h2E0 + 32'(k), k == 2);
        wait_bp("t6", 2, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_out_valid", out_valid, 0);
        chk("t6_rst_out_data",  out_data,  0);
        chk("t6_rst_req_ready", req_ready, 0);
        chk("t6_rst_busy",      busy,      0);
        chk("t6_rst_gnt_id",    gnt_id,    0);
        clear_stim();
        push(3, 32'h3D0, 1'b1);
        push(0, 32'h0D0, 1'b1);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        drain("t6");
        exp_q.push_back(32'h0D0);
        exp_q.push_back(32'h3D0);
        check_stream("t6");
        exp_g.push_back(0);
        exp_g.push_back(3);
        check_grants("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
